// File: rtl/fp_addsub_sequencer_pkg.sv
// Shared constants, field slices and FSM encoding for the FP add/sub sequencer.
package fp_addsub_sequencer_pkg;
  localparam int W_EXP     = 8;
  localparam int W_MANT    = 23;
  localparam int MAX_ALIGN = 26;
  localparam int W_SIG     = W_MANT + 1;
  localparam int W_CNT     = $clog2(MAX_ALIGN + 1);

  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int FRAC_HI  = 22;
  localparam int FRAC_LO  = 0;

  localparam logic [W_EXP-1:0] ALIGN_SAT = W_EXP'(MAX_ALIGN);
  localparam logic [W_EXP:0]   EXP_INF   = {1'b0, {W_EXP{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/fp_addsub_sequencer_if.sv
// Operand-in / result-out handshake bundle for the FP add/sub sequencer.
interface fp_addsub_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        ovf;
  logic        busy;

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, ovf, busy
  );
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, ovf, busy
  );
endinterface

// File: rtl/fp_addsub_sequencer_mant.sv
// Combinational significand add/sub; operand A is already the larger magnitude.
module fp_mant_addsub
  import fp_addsub_sequencer_pkg::*;
(
  input  logic [W_SIG-1:0] i_ma,
  input  logic [W_SIG-1:0] i_mb,
  input  logic             i_sa,
  input  logic             i_sb,
  output logic [W_SIG:0]   o_sum,
  output logic             o_sign
);
  always_comb begin
    o_sum  = '0;
    o_sign = i_sa;
    if (i_sa == i_sb) o_sum = {1'b0, i_ma} + {1'b0, i_mb};
    else              o_sum = {1'b0, i_ma} - {1'b0, i_mb};
    // exact cancellation always yields +0
    if (o_sum == '0) o_sign = 1'b0;
  end
endmodule

// File: rtl/fp_addsub_sequencer.sv
// Multi-cycle IEEE-754 single add/sub: unpack/swap, 1-bit/cycle align, add, 1-bit/cycle normalize, pack.
module fp_addsub_sequencer
  import fp_addsub_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  fp_addsub_sequencer_if.slave  bus
);
  state_t r_state, w_next;

  logic [W_SIG-1:0] r_ma, r_mb;
  logic             r_sa, r_sb, r_sign;
  logic [W_EXP:0]   r_exp;
  logic [W_CNT-1:0] r_cnt;
  logic [W_SIG:0]   r_mant;
  logic [31:0]      r_result;
  logic             r_zero, r_ovf;

  logic [W_EXP-1:0] w_ea, w_eb, w_el, w_es, w_d;
  logic [W_SIG-1:0] w_ma, w_mb;
  logic             w_sa, w_sb, w_swap;
  logic [W_CNT-1:0] w_cnt0;
  logic [W_SIG:0]   w_sum;
  logic             w_sign;
  logic [W_EXP:0]   w_exp_inc;

  // Unpack with denormal flush, then order operands by magnitude.
  always_comb begin
    w_ea   = bus.a[EXP_HI:EXP_LO];
    w_eb   = bus.b[EXP_HI:EXP_LO];
    w_ma   = (w_ea == '0) ? '0 : {1'b1, bus.a[FRAC_HI:FRAC_LO]};
    w_mb   = (w_eb == '0) ? '0 : {1'b1, bus.b[FRAC_HI:FRAC_LO]};
    w_sa   = bus.a[SIGN_BIT];
    w_sb   = bus.b[SIGN_BIT] ^ bus.op;
    w_swap = (w_eb > w_ea) || ((w_eb == w_ea) && (w_mb > w_ma));
    w_el   = w_swap ? w_eb : w_ea;
    w_es   = w_swap ? w_ea : w_eb;
    w_d    = w_el - w_es;
    w_cnt0 = (w_d > ALIGN_SAT) ? W_CNT'(MAX_ALIGN) : w_d[W_CNT-1:0];
  end

  fp_mant_addsub u_mant (
    .i_ma  (r_ma),
    .i_mb  (r_mb),
    .i_sa  (r_sa),
    .i_sb  (r_sb),
    .o_sum (w_sum),
    .o_sign(w_sign)
  );

  assign w_exp_inc = r_exp + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_next = S_ALIGN;
      S_ALIGN: if (r_cnt == '0) w_next = S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM:  if (r_mant[W_SIG] || (r_mant == '0) || r_mant[W_SIG-1] || (r_exp == 9'd1))
                 w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == S_IDLE);
    bus.out_valid = (r_state == S_DONE);
    bus.busy      = (r_state != S_IDLE);
    bus.result    = r_result;
    bus.zero      = r_zero;
    bus.ovf       = r_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ma     <= '0;
      r_mb     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_cnt    <= '0;
      r_mant   <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_ma   <= w_swap ? w_mb : w_ma;
          r_mb   <= w_swap ? w_ma : w_mb;
          r_sa   <= w_swap ? w_sb : w_sa;
          r_sb   <= w_swap ? w_sa : w_sb;
          r_exp  <= {1'b0, w_el};
          r_cnt  <= w_cnt0;
          r_zero <= 1'b0;
          r_ovf  <= 1'b0;
        end
        S_ALIGN: if (r_cnt != '0) begin
          r_mb  <= r_mb >> 1;
          r_cnt <= r_cnt - 1'b1;
        end
        S_ADD: begin
          r_mant <= w_sum;
          r_sign <= w_sign;
        end
        S_NORM: begin
          if (r_mant[W_SIG]) begin
            // carry-out: renormalise right and pack in the same cycle
            if (w_exp_inc >= EXP_INF) begin
              r_ovf    <= 1'b1;
              r_result <= {r_sign, 8'hFF, 23'h0};
            end else begin
              r_result <= {r_sign, w_exp_inc[W_EXP-1:0], r_mant[W_SIG-1:1]};
            end
          end else if (r_mant == '0) begin
            r_zero   <= 1'b1;
            r_result <= '0;
          end else if (r_mant[W_SIG-1]) begin
            r_result <= {r_sign, r_exp[W_EXP-1:0], r_mant[W_MANT-1:0]};
          end else if (r_exp == 9'd1) begin
            r_zero   <= 1'b1;
            r_result <= {r_sign, 31'h0};
          end else begin
            r_mant <= r_mant << 1;
            r_exp  <= r_exp - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
